// File: rtl/vrf_wb_arbiter.sv
// Write-back port arbiter for the vector register file: grants whole VFU/VLSU
// bursts round-robin and steps the element-chunk select one beat at a time.
module vrf_wb_arbiter #(
  parameter  int DATA_WIDTH = 32,
  parameter  int LANES      = 4,
  parameter  int VLEN       = 512,
  localparam int BW         = LANES * DATA_WIDTH,
  localparam int BEATS      = VLEN / BW,
  localparam int CW         = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          vfu_req_i,
  input  logic [4:0]    vfu_addr_i,
  input  logic [BW-1:0] vfu_data_i,
  output logic          vfu_gnt_o,
  input  logic          vlsu_req_i,
  input  logic [4:0]    vlsu_addr_i,
  input  logic [BW-1:0] vlsu_data_i,
  output logic          vlsu_gnt_o,
  output logic          vd1_wr_en_o,
  output logic [4:0]    vd1_addr_o,
  output logic [BW-1:0] vd1_data_o,
  output logic [CW-1:0] vrf_element_sel_o,
  output logic          wb_src_o,
  output logic          wb_done_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic [4:0]    addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          prio_q, prio_d;

  logic          winner;
  logic          beat;
  logic          own_req;
  logic [BW-1:0] own_data;
  logic          last_beat;

  assign own_req   = owner_q ? vlsu_req_i  : vfu_req_i;
  assign own_data  = owner_q ? vlsu_data_i : vfu_data_i;
  assign last_beat = (cnt_q == CW'(BEATS - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      prio_q  <= prio_d;
    end
  end

  // A dropped owner request only stalls the burst; the grant is held until the last beat.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    prio_d     = prio_q;
    winner     = 1'b0;
    beat       = 1'b0;
    vfu_gnt_o  = 1'b0;
    vlsu_gnt_o = 1'b0;
    wb_done_o  = 1'b0;

    case (state_q)
      IDLE: begin
        if (vfu_req_i || vlsu_req_i) begin
          winner  = (vfu_req_i && vlsu_req_i) ? prio_q : vlsu_req_i;
          state_d = BURST;
          owner_d = winner;
          addr_d  = winner ? vlsu_addr_i : vfu_addr_i;
          cnt_d   = '0;
        end
      end
      BURST: begin
        vfu_gnt_o  = ~owner_q;
        vlsu_gnt_o = owner_q;
        beat       = own_req;
        if (beat) begin
          if (last_beat) begin
            wb_done_o = 1'b1;
            state_d   = IDLE;
            cnt_d     = '0;
            prio_d    = ~owner_q;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign vd1_wr_en_o       = beat;
  assign vd1_data_o        = beat ? own_data : '0;
  assign vd1_addr_o        = addr_q;
  assign vrf_element_sel_o = cnt_q;
  assign wb_src_o          = owner_q;

endmodule

// File: tb/tb_vrf_wb_arbiter.sv
// Randomised scoreboard bench for vrf_wb_arbiter: a burst-level reference model
// predicts every cycle's port activity; a negedge monitor compares the DUT.
module tb_vrf_wb_arbiter;

  localparam int DW    = 32;
  localparam int LN    = 4;
  localparam int VL    = 512;
  localparam int BW    = LN * DW;
  localparam int BEATS = VL / BW;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          vfu_req_i, vlsu_req_i;
  logic [4:0]    vfu_addr_i, vlsu_addr_i;
  logic [BW-1:0] vfu_data_i, vlsu_data_i;
  logic          vfu_gnt_o, vlsu_gnt_o;
  logic          vd1_wr_en_o;
  logic [4:0]    vd1_addr_o;
  logic [BW-1:0] vd1_data_o;
  logic [CW-1:0] vrf_element_sel_o;
  logic          wb_src_o, wb_done_o;

  vrf_wb_arbiter #(.DATA_WIDTH(DW), .LANES(LN), .VLEN(VL)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .vfu_req_i(vfu_req_i), .vfu_addr_i(vfu_addr_i), .vfu_data_i(vfu_data_i), .vfu_gnt_o(vfu_gnt_o),
    .vlsu_req_i(vlsu_req_i), .vlsu_addr_i(vlsu_addr_i), .vlsu_data_i(vlsu_data_i), .vlsu_gnt_o(vlsu_gnt_o),
    .vd1_wr_en_o(vd1_wr_en_o), .vd1_addr_o(vd1_addr_o), .vd1_data_o(vd1_data_o),
    .vrf_element_sel_o(vrf_element_sel_o), .wb_src_o(wb_src_o), .wb_done_o(wb_done_o)
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct packed {
    logic          gv;
    logic          gl;
    logic          wr;
    logic [CW-1:0] sel;
    logic [4:0]    addr;
    logic          src;
    logic          done;
  } ctrl_t;

  typedef struct packed {
    logic [CW-1:0] sel;
    logic [BW-1:0] data;
  } wr_t;

  ctrl_t ctrl_q[$];
  wr_t   wr_q[$];
  int    n_cmp = 0;
  int    n_mis = 0;
  bit    started = 0;

  // Requester-side driver state, index 0 = VFU, 1 = VLSU
  logic [4:0]    pend_v[$];
  logic [4:0]    pend_l[$];
  bit            active[2];
  int            beat[2];
  int            stall_left[2];
  int            stall_plan[2];
  int            stall_len[2];
  logic [4:0]    cur_addr[2];
  logic [BW-33:0] salt[2];
  bit            took[2];
  bit            ownd[2];
  bit            rand_stall_en = 0;
  bit            zero_salt = 1;

  task automatic checkOutput(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pend_size(input int s);
    return (s == 0) ? pend_v.size() : pend_l.size();
  endfunction

  function automatic logic [4:0] pend_pop(input int s);
    if (s == 0) return pend_v.pop_front();
    return pend_l.pop_front();
  endfunction

  // Handshake sampling for the drivers, away from the clock edge
  initial forever begin
    @(negedge clk_i);
    took[0] = vfu_req_i && vfu_gnt_o;
    took[1] = vlsu_req_i && vlsu_gnt_o;
    ownd[0] = vfu_gnt_o;
    ownd[1] = vlsu_gnt_o;
  end

  // One cycle of requester behaviour; reset value applies to the coming cycle
  task automatic applyStimulus(input bit rst_val);
    bit req[2];
    bit fresh;
    @(posedge clk_i);
    #1;
    for (int s = 0; s < 2; s++) begin
      fresh = 0;
      if (reset_i) begin
        active[s] = 0; beat[s] = 0; stall_left[s] = 0;
      end else if (took[s]) begin
        beat[s]++;
        if (beat[s] == BEATS) begin
          active[s] = 0; beat[s] = 0;
        end
      end
      if (!active[s] && pend_size(s) > 0) begin
        active[s]   = 1;
        fresh       = 1;
        beat[s]     = 0;
        cur_addr[s] = pend_pop(s);
        salt[s]     = zero_salt ? '0 : {$urandom, $urandom, $urandom};
      end
      if (active[s] && !fresh && ownd[s] && !reset_i && stall_left[s] == 0) begin
        if (stall_plan[s] == beat[s]) begin
          stall_left[s] = stall_len[s];
          stall_plan[s] = -1;
        end else if (rand_stall_en && $urandom_range(0, 5) == 0) begin
          stall_left[s] = $urandom_range(1, 3);
        end
      end
      req[s] = active[s] && (stall_left[s] == 0);
      if (stall_left[s] > 0) stall_left[s]--;
    end
    vfu_req_i   = req[0];
    vfu_addr_i  = cur_addr[0];
    vfu_data_i  = {salt[0], 32'(beat[0])};
    vlsu_req_i  = req[1];
    vlsu_addr_i = cur_addr[1];
    vlsu_data_i = {salt[1], 32'(beat[1])};
    reset_i     = rst_val;
  endtask

  // Reference model: the port is either free or owned by one requester that
  // has written some number of beats; when free, contention goes to the
  // requester not served last.
  initial begin
    bit         busy = 0;
    bit         owner = 0;
    bit         turn = 0;
    int         done_beats = 0;
    logic [4:0] addr = '0;
    bit         rq[2];
    logic [BW-1:0] dat[2];
    ctrl_t      e;
    wr_t        w;
    forever begin
      @(posedge clk_i);
      #2;
      started = 1;
      rq[0]  = vfu_req_i;  rq[1]  = vlsu_req_i;
      dat[0] = vfu_data_i; dat[1] = vlsu_data_i;
      e.gv   = busy && !owner;
      e.gl   = busy && owner;
      e.wr   = busy && rq[owner];
      e.sel  = CW'(done_beats);
      e.addr = addr;
      e.src  = owner;
      e.done = e.wr && (done_beats == BEATS - 1);
      ctrl_q.push_back(e);
      if (e.wr) begin
        w.sel  = CW'(done_beats);
        w.data = dat[owner];
        wr_q.push_back(w);
      end
      if (reset_i) begin
        busy = 0; owner = 0; turn = 0; done_beats = 0; addr = '0;
      end else if (!busy) begin
        if (rq[0] || rq[1]) begin
          owner      = (rq[0] && rq[1]) ? turn : rq[1];
          addr       = owner ? vlsu_addr_i : vfu_addr_i;
          busy       = 1;
          done_beats = 0;
        end
      end else if (e.wr) begin
        done_beats++;
        if (done_beats == BEATS) begin
          busy       = 0;
          done_beats = 0;
          turn       = !owner;
        end
      end
    end
  end

  // Monitor: control every cycle, data whenever the DUT presents a write
  initial forever begin
    ctrl_t e;
    wr_t   w;
    @(negedge clk_i);
    if (started) begin
      if (ctrl_q.size() == 0) begin
        checkOutput("ctrl_queue_nonempty", 0, 1);
      end else begin
        e = ctrl_q.pop_front();
        checkOutput("grant", {vfu_gnt_o, vlsu_gnt_o}, {e.gv, e.gl});
        checkOutput("wr_en", vd1_wr_en_o, e.wr);
        checkOutput("element_sel", vrf_element_sel_o, e.sel);
        checkOutput("vd1_addr", vd1_addr_o, e.addr);
        checkOutput("wb_src", wb_src_o, e.src);
        checkOutput("wb_done", wb_done_o, e.done);
      end
      if (vd1_wr_en_o === 1'b1) begin
        if (wr_q.size() == 0) begin
          checkOutput("write_expected", 0, 1);
        end else begin
          w = wr_q.pop_front();
          checkOutput("wr_data", vd1_data_o, w.data);
          checkOutput("wr_sel", vrf_element_sel_o, w.sel);
        end
      end else begin
        checkOutput("idle_data_zero", vd1_data_o, '0);
      end
    end
  end

  initial begin
    int k;
    reset_i = 1; vfu_req_i = 0; vlsu_req_i = 0;
    vfu_addr_i = '0; vlsu_addr_i = '0; vfu_data_i = '0; vlsu_data_i = '0;
    for (int s = 0; s < 2; s++) begin
      active[s] = 0; beat[s] = 0; stall_left[s] = 0; stall_plan[s] = -1;
      stall_len[s] = 0; cur_addr[s] = '0; salt[s] = '0; took[s] = 0; ownd[s] = 0;
    end
    applyStimulus(1);
    applyStimulus(0);

    // Single VFU burst to v5 with data equal to the beat index
    pend_v.push_back(5'd5);
    repeat (8) applyStimulus(0);

    // Simultaneous requests straight after reset: VFU first, then VLSU
    applyStimulus(1);
    pend_v.push_back(5'd3);
    pend_l.push_back(5'd9);
    repeat (14) applyStimulus(0);

    // Both held high: bursts must alternate with one idle bubble
    zero_salt = 0;
    for (int i = 0; i < 4; i++) begin
      pend_v.push_back(5'($urandom));
      pend_l.push_back(5'($urandom));
    end
    repeat (45) applyStimulus(0);

    // VLSU stalls for two cycles after its first beat
    stall_plan[1] = 1;
    stall_len[1]  = 2;
    pend_l.push_back(5'd17);
    repeat (12) applyStimulus(0);

    // Reset lands on beat 2 of a VFU burst, then a fresh burst
    pend_v.push_back(5'd21);
    repeat (3) applyStimulus(0);
    applyStimulus(1);
    pend_v.push_back(5'd22);
    repeat (8) applyStimulus(0);

    // Random traffic with random stalls and occasional resets
    rand_stall_en = 1;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          if (pend_v.size() < 3) pend_v.push_back(5'($urandom));
        end else begin
          if (pend_l.size() < 3) pend_l.push_back(5'($urandom));
        end
      end
      applyStimulus($urandom_range(0, 399) == 0);
    end

    rand_stall_en = 0;
    k = 0;
    while ((active[0] || active[1] || pend_v.size() > 0 || pend_l.size() > 0) && k < 200) begin
      applyStimulus(0);
      k++;
    end
    repeat (3) applyStimulus(0);
    checkOutput("drain_idle", {active[0], active[1]}, 2'b00);
    checkOutput("wr_queue_drained", wr_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
